// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: runs a 16-bit add/sub/OR/AND as two byte passes
// through an external 8-bit ALU, low byte first, with the carry chained.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 add, 01 sub, 10 OR, 11 AND
//   cmd_a, cmd_b         16-bit operands
//   cmd_cin              carry/borrow in (arithmetic ops only)
//   alu_a, alu_b         byte operands to the ALU
//   alu_op, alu_cin      op code and carry/borrow to the ALU
//   alu_y, alu_cout      ALU result byte and bit 8
//   rsp_valid/rsp_ready  response handshake
//   rsp_y, rsp_cout      16-bit result and final carry/borrow
//   stat_cnt             response count (only with ALU_CTRL_CNT_EN)
//
// Parameter ALU_LAT: extra wait cycles per byte pass before the ALU
// result is sampled.
// Macro ALU_CTRL_CNT_EN: adds the stat_cnt response counter.

module alu_cmd_ctrl #(
    parameter int ALU_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_cin,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_cin,
    input  logic [7:0]  alu_y,
    input  logic        alu_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_y,
    output logic        rsp_cout
`ifdef ALU_CTRL_CNT_EN
    ,
    output logic [15:0] stat_cnt
`endif
);

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(ALU_LAT);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]    op_q;
    logic [15:0]   a_q;
    logic [15:0]   b_q;
    logic          cin_q;
    logic          carry_q;
    logic [7:0]    lo_q;
    logic [CW-1:0] wait_q;

    logic last;
    logic arith;
    logic accept;
    logic cap_lo;
    logic cap_hi;
    logic rsp_fire;

    assign last  = (wait_q == LAST);
    assign arith = ~op_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_op    = 2'b00;
        alu_cin   = 1'b0;
        accept    = 1'b0;
        cap_lo    = 1'b0;
        cap_hi    = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = LO;
                end
            end
            LO: begin
                alu_a   = a_q[7:0];
                alu_b   = b_q[7:0];
                alu_op  = op_q;
                alu_cin = arith & cin_q;
                if (last) begin
                    cap_lo    = 1'b1;
                    state_nxt = HI;
                end
            end
            HI: begin
                alu_a   = a_q[15:8];
                alu_b   = b_q[15:8];
                alu_op  = op_q;
                alu_cin = arith & carry_q;
                if (last) begin
                    cap_hi    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counter restarts on every state change and only runs in LO/HI.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_nxt != state) begin
            wait_q <= '0;
        end else if (state == LO || state == HI) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    // The low byte is staged in lo_q so rsp_y only changes when the
    // full result is ready, keeping the old response visible until then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= 2'b00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            lo_q     <= 8'h00;
            rsp_y    <= 16'h0000;
            rsp_cout <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= cmd_op;
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                cin_q <= cmd_cin;
            end
            if (cap_lo) begin
                lo_q    <= alu_y;
                carry_q <= alu_cout;
            end
            if (cap_hi) begin
                rsp_y    <= {alu_y, lo_q};
                rsp_cout <= alu_cout;
            end
        end
    end

`ifdef ALU_CTRL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cnt <= 16'h0000;
        end else if (rsp_fire) begin
            stat_cnt <= stat_cnt + 16'h0001;
        end
    end
`else
    logic unused_fire;
    assign unused_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: scoreboard bench for alu_cmd_ctrl with ALU_LAT=0
// (combinational ALU) and ALU_LAT=2 (two-stage pipelined ALU model).

module tb_alu_cmd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        cmd_valid [2];
    logic        rsp_ready [2];
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_cin;

    logic        cmd_ready [2];
    logic [7:0]  alu_a     [2];
    logic [7:0]  alu_b     [2];
    logic [1:0]  alu_op    [2];
    logic        alu_cin   [2];
    logic [7:0]  alu_y     [2];
    logic        alu_cout  [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_y     [2];
    logic        rsp_cout  [2];
`ifdef ALU_CTRL_CNT_EN
    logic [15:0] stat_cnt  [2];
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [16:0] sb[$];

    alu_cmd_ctrl #(.ALU_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_cin(cmd_cin),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_op(alu_op[0]), .alu_cin(alu_cin[0]),
        .alu_y(alu_y[0]), .alu_cout(alu_cout[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_y(rsp_y[0]), .rsp_cout(rsp_cout[0])
`ifdef ALU_CTRL_CNT_EN
        , .stat_cnt(stat_cnt[0])
`endif
    );

    alu_cmd_ctrl #(.ALU_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_cin(cmd_cin),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_op(alu_op[1]), .alu_cin(alu_cin[1]),
        .alu_y(alu_y[1]), .alu_cout(alu_cout[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_y(rsp_y[1]), .rsp_cout(rsp_cout[1])
`ifdef ALU_CTRL_CNT_EN
        , .stat_cnt(stat_cnt[1])
`endif
    );

    function automatic logic [8:0] alu_f(input logic [1:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic       cin);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b} + {8'd0, cin};
            2'b01:   return {1'b0, a} - {1'b0, b} - {8'd0, cin};
            2'b10:   return {1'b0, a | b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    // Latency-2 ALU: result appears two clocks after its inputs.
    logic [8:0] p1, p2;
    always @(posedge clk) begin
        p1 <= alu_f(alu_op[1], alu_a[1], alu_b[1], alu_cin[1]);
        p2 <= p1;
    end

    always_comb begin
        {alu_cout[0], alu_y[0]} = alu_f(alu_op[0], alu_a[0],
                                        alu_b[0], alu_cin[0]);
        {alu_cout[1], alu_y[1]} = p2;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input int d, input logic [1:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input int hold,
                           input int lat);
        logic [16:0] full;
        logic [16:0] exp;
        logic [8:0]  lo_r;
        logic [15:0] y_s;
        logic        c_s;
        int          n;
        case (op)
            2'b00:   full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            2'b01:   full = {1'b0, a} - {1'b0, b} - {16'd0, cin};
            2'b10:   full = {1'b0, a | b};
            default: full = {1'b0, a & b};
        endcase
        lo_r = alu_f(op, a[7:0], b[7:0], cin);
        @(negedge clk);
        chk("idle_ready", cmd_ready[d], 1);
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_cin = cin;
        cmd_valid[d] = 1'b1;
        sb.push_back(full);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        n = 0;
        while (!rsp_valid[d] && n < 60) begin
            if (n == 0) begin
                chk("lo_a", alu_a[d], a[7:0]);
                chk("lo_b", alu_b[d], b[7:0]);
                chk("lo_op", alu_op[d], op);
                chk("lo_cin", alu_cin[d], op[1] ? 1'b0 : cin);
                chk("busy_ready", cmd_ready[d], 0);
                // Busy-time command with other operands must be ignored.
                cmd_valid[d] = 1'b1;
                cmd_a = ~a;
                cmd_op = ~op;
            end else begin
                cmd_valid[d] = 1'b0;
            end
            if (n == lat / 2) begin
                chk("hi_a", alu_a[d], a[15:8]);
                chk("hi_b", alu_b[d], b[15:8]);
                chk("hi_cin", alu_cin[d], op[1] ? 1'b0 : lo_r[8]);
            end
            @(negedge clk);
            n++;
        end
        cmd_valid[d] = 1'b0;
        chk("latency", n, lat);
        y_s = rsp_y[d];
        c_s = rsp_cout[d];
        repeat (hold) begin
            @(negedge clk);
            chk("hold_y", rsp_y[d], y_s);
            chk("hold_cout", rsp_cout[d], c_s);
            chk("hold_valid", rsp_valid[d], 1);
            chk("hold_ready", cmd_ready[d], 0);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 17'h0;
        chk("rsp_y", rsp_y[d], exp[15:0]);
        chk("rsp_cout", rsp_cout[d], exp[16]);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("post_ready", cmd_ready[d], 1);
        chk("post_valid", rsp_valid[d], 0);
        chk("post_y", rsp_y[d], exp[15:0]);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [15:0] r_a;
        logic [15:0] r_b;
        logic        r_c;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            cmd_valid[i] = 1'b0;
            rsp_ready[i] = 1'b0;
        end
        cmd_op = 2'b00;
        cmd_a = 16'h0;
        cmd_b = 16'h0;
        cmd_cin = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", rsp_valid[i], 0);
            chk("rst_y", rsp_y[i], 0);
            chk("rst_cout", rsp_cout[i], 0);
            chk("rst_ready", cmd_ready[i], 1);
            chk("rst_alu_a", alu_a[i], 0);
            chk("rst_alu_cin", alu_cin[i], 0);
            rst_n[i] = 1'b1;
        end

        run_cmd(0, 2'b00, 16'h00FF, 16'h0001, 1'b0, 0, 2);
        run_cmd(0, 2'b00, 16'hFFFF, 16'h0000, 1'b1, 0, 2);
        run_cmd(0, 2'b01, 16'h0100, 16'h0001, 1'b0, 0, 2);
        run_cmd(0, 2'b01, 16'h0000, 16'h0001, 1'b0, 0, 2);
        run_cmd(0, 2'b10, 16'h0F0F, 16'hF000, 1'b1, 5, 2);

`ifdef ALU_CTRL_CNT_EN
        chk("cnt_before", stat_cnt[1], 0);
`endif
        run_cmd(1, 2'b11, 16'hF0F0, 16'hFF00, 1'b0, 0, 6);
`ifdef ALU_CTRL_CNT_EN
        chk("cnt_after", stat_cnt[1], 1);
`endif
        run_cmd(1, 2'b01, 16'h1234, 16'h0235, 1'b1, 2, 6);
        run_cmd(1, 2'b00, 16'h80FF, 16'h8001, 1'b0, 0, 6);

        // Abort during the HI pass.
        @(negedge clk);
        cmd_op = 2'b00;
        cmd_a = 16'h1234;
        cmd_b = 16'h0001;
        cmd_cin = 1'b0;
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort_in_hi", alu_a[0], 8'h12);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        chk("abort_ready", cmd_ready[0], 1);
        chk("abort_valid", rsp_valid[0], 0);
        chk("abort_alu_a", alu_a[0], 0);
        chk("abort_y", rsp_y[0], 0);
`ifdef ALU_CTRL_CNT_EN
        chk("abort_cnt", stat_cnt[0], 0);
`endif
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid[0], 0);
        end
        run_cmd(0, 2'b00, 16'h0001, 16'h0001, 1'b0, 0, 2);

        for (int i = 0; i < 8; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a = 16'($urandom);
            r_b = 16'($urandom);
            r_c = 1'($urandom_range(0, 1));
            run_cmd(i % 2, r_op, r_a, r_b, r_c, i % 3,
                    (i % 2 == 1) ? 6 : 2);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
